image_streamer: RTL and testbench

//  Frame source for the CNN datapath. On a start pulse it reads one HxW image

---
 rtl/image_streamer.sv | 129 ++++++++++++
 tb/tb_image_streamer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/image_streamer.sv
// Raster-order frame reader: pulls H*W pixels from a 1-cycle-latency ROM and
// presents them on a valid/ready stream with end-of-row / end-of-frame flags.
module image_streamer #(
    parameter int H  = 28,
    parameter int W  = 28,
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_eol,
    output logic          m_last,
    output logic          busy,
    output logic          done
);
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(H*W-1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_addr;
    logic          r_pend;
    logic [DW-1:0] r_q0, r_q1;
    logic [1:0]    r_cnt;
    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          r_done;

    logic          w_pop, w_start, w_last_rd, w_col_end, w_row_end;
    logic [2:0]    w_occ;

    assign w_pop     = m_valid & m_ready;
    assign w_start   = (r_state == S_IDLE) & start;
    assign w_last_rd = mem_en & (r_addr == LAST_ADDR);
    assign w_col_end = (r_col == CW'(W-1));
    assign w_row_end = (r_row == RW'(H-1));
    // occupancy seen by the next read: buffered + in flight, after this cycle's pop
    assign w_occ     = {1'b0, r_cnt} + {2'b0, r_pend} - {2'b0, w_pop};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start)            w_next = S_STREAM;
            S_STREAM: if (w_last_rd)        w_next = S_DRAIN;
            S_DRAIN:  if (w_pop && m_last)  w_next = S_IDLE;
            default:                        w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_en = (r_state == S_STREAM) && (w_occ < 3'd2);
        busy   = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr <= '0;
            r_pend <= 1'b0;
            r_q0   <= '0;
            r_q1   <= '0;
            r_cnt  <= 2'd0;
            r_row  <= '0;
            r_col  <= '0;
            r_done <= 1'b0;
        end else begin
            r_pend <= mem_en;
            r_done <= (r_state == S_DRAIN) && w_pop && m_last;

            if (w_start)     r_addr <= '0;
            else if (mem_en) r_addr <= r_addr + AW'(1);

            // 2-entry FIFO; r_q0 is the head. Overflow cannot occur because
            // reads are throttled by w_occ.
            case ({r_pend, w_pop})
                2'b01: begin
                    r_q0  <= r_q1;
                    r_cnt <= r_cnt - 2'd1;
                end
                2'b10: begin
                    if (r_cnt == 2'd0) r_q0 <= mem_rdata;
                    else               r_q1 <= mem_rdata;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) r_q0 <= mem_rdata;
                    else begin
                        r_q0 <= r_q1;
                        r_q1 <= mem_rdata;
                    end
                end
                default: ;
            endcase

            if (w_start) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_pop) begin
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_row_end ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
            end
        end
    end

    assign mem_addr = r_addr;
    assign m_valid  = (r_cnt != 2'd0);
    assign m_data   = r_q0;
    assign m_eol    = m_valid & w_col_end;
    assign m_last   = m_eol & w_row_end;
    assign done     = r_done;

endmodule

// File: tb/tb_image_streamer.sv
// Directed bench for image_streamer: ROM[i]=i, a per-cycle stream monitor and
// five scenarios (full speed, throttled, stalled, start-while-busy, abort).
module tb_image_streamer;
    localparam int H = 28, W = 28, DW = 16, AW = 10, N = H*W;

    logic          clk, rst, start, mem_en, m_valid, m_ready, m_eol, m_last, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata, m_data;

    int n_vec = 0, n_err = 0;
    int cyc = 0, issued = 0, accepted = 0, exp_idx = 0;
    int first_cyc = 0, last_cyc = 0, done_cyc = 0;
    int rdy_mode = 1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_vec = '0;

    image_streamer #(.H(H), .W(W), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_eol(m_eol), .m_last(m_last), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (mem_en) mem_rdata <= {6'd0, mem_addr};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ready pattern: 0 = held low, 1 = held high, 2 = 1,0,0,1 repeating
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       m_ready = 1'b0;
                1:       m_ready = 1'b1;
                default: begin
                    m_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) prev_stall = 1'b0;
        else begin
            if (mem_en) begin
                chk("addr", mem_addr, issued);
                issued++;
            end
            if (prev_stall) chk("hold", {m_valid, m_data, m_eol, m_last}, prev_vec);
            if (m_valid && m_ready) begin
                chk("data", m_data, exp_idx);
                chk("eol", m_eol, (exp_idx % W) == W-1);
                chk("last", m_last, exp_idx == N-1);
                if (accepted == 0) first_cyc = cyc;
                last_cyc = cyc;
                exp_idx++;
                accepted++;
            end
            if (busy) chk("outstanding<=2", (issued - accepted) <= 2, 1);
            if (done) done_cyc = cyc;
            prev_stall = m_valid && !m_ready;
            prev_vec   = {13'd0, m_valid, m_data, m_eol, m_last};
        end
    end

    task automatic frame_reset();
        issued = 0; accepted = 0; exp_idx = 0;
    endtask

    task automatic start_frame();
        frame_reset();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        int i;
        for (i = 0; i < lim; i++) begin
            @(negedge clk);
            if (done) break;
        end
        #1;
        chk("done_timeout", i < lim, 1);
    endtask

    task automatic wait_beats(input int n);
        int i;
        for (i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (accepted >= n) break;
        end
        #1;
        chk("beat_timeout", i < 4000, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {mem_en, mem_addr, m_valid, m_data, m_eol, m_last, busy, done}, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0;
        #12;
        chk_all_zero("reset_outputs");
        @(posedge clk); #1 rst = 1'b1;

        // 1: full speed
        rdy_mode = 1;
        @(posedge clk); #1;
        start_frame();
        @(negedge clk);
        chk("lat_mem_en", mem_en, 1);
        chk("lat_addr0", mem_addr, 0);
        chk("lat_valid_k1", m_valid, 0);
        @(negedge clk);
        chk("lat_valid_k2", m_valid, 0);
        @(negedge clk);
        chk("lat_valid_k3", {m_valid, m_data}, {1'b1, 16'd0});
        wait_done(2000);
        chk("t1_beats", accepted, N);
        chk("t1_no_bubbles", last_cyc - first_cyc, N-1);
        chk("t1_done_lat", done_cyc - last_cyc, 1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // 2: throttled ready 1,0,0,1
        rdy_mode = 2;
        @(posedge clk); #1;
        start_frame();
        wait_done(4000);
        chk("t2_beats", accepted, N);
        chk("t2_reads", issued, N);

        // 3: stalled for 50 cycles
        rdy_mode = 0;
        @(posedge clk); #1;
        start_frame();
        repeat (50) @(negedge clk);
        #1;
        chk("t3_valid_data", {m_valid, m_data}, {1'b1, 16'd0});
        chk("t3_reads", issued, 2);
        chk("t3_none_taken", accepted, 0);
        rdy_mode = 1;
        wait_done(2000);
        chk("t3_beats", accepted, N);

        // 4: start while busy, then back-to-back frame from the done cycle
        @(posedge clk); #1;
        start_frame();
        wait_beats(100);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(2000);
        chk("t4_beats", accepted, N);
        chk("t4_done", done, 1);
        frame_reset();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t4_f2_addr0", {mem_en, mem_addr}, {1'b1, 10'd0});
        wait_done(2000);
        chk("t4_f2_beats", accepted, N);

        // 5: asynchronous abort mid-frame
        @(posedge clk); #1;
        start_frame();
        wait_beats(300);
        #1 rst = 1'b0;
        #1;
        chk_all_zero("t5_async_reset");
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        start_frame();
        repeat (3) @(negedge clk);
        chk("t5_restart", {m_valid, m_data}, {1'b1, 16'd0});
        wait_done(2000);
        chk("t5_beats", accepted, N);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
